// File: rtl/isqrt_pipe_if.sv
// rtl/isqrt_pipe_if.sv - argument/result bundle for the pipelined integer square root
interface isqrt_pipe_if;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;

    modport master (output x_vld, output x, input y_vld, input y);
    modport slave  (input x_vld, input x, output y_vld, output y);
endinterface

// File: rtl/isqrt_pipe.sv
// rtl/isqrt_pipe.sv - restoring bit-by-bit isqrt, 16/n_stages root bits resolved per register stage
module isqrt_pipe #(
    parameter int n_stages = 16
) (
    input  logic        clk,
    input  logic        rst,
    isqrt_pipe_if.slave io
);
    localparam int bits_per_stage = 16 / n_stages;

    logic [n_stages-1:0]        vld_q;
    logic [n_stages-1:0][15:0]  r_q;

    logic [n_stages-1:0]        in_vld;
    logic [n_stages-1:0][31:0]  in_x;
    logic [n_stages-1:0][15:0]  in_r;
    logic [n_stages-1:0][15:0]  nxt_r;

    // Try each candidate bit from MSB down; keep it when the trial square still fits under x.
    function automatic logic [15:0] resolve(input logic [31:0] xv, input logic [15:0] r_in, input int stage);
        logic [15:0] r;
        logic [15:0] t;
        logic [31:0] sq;
        r = r_in;
        for (int i = 0; i < bits_per_stage; i++) begin
            t  = r | (16'd1 << (15 - stage * bits_per_stage - i));
            sq = {16'd0, t} * {16'd0, t};
            if (sq <= xv) r = t;
        end
        return r;
    endfunction

    assign in_vld[0] = io.x_vld;
    assign in_x[0]   = io.x;
    assign in_r[0]   = '0;

    // The last stage needs no radicand copy, so x registers exist only between stages.
    generate
        if (n_stages > 1) begin : g_xpipe
            logic [n_stages-2:0][31:0] x_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_q <= '0;
                end else begin
                    for (int s = 0; s < n_stages - 1; s++) begin
                        if (in_vld[s]) x_q[s] <= in_x[s];
                    end
                end
            end

            assign in_vld[n_stages-1:1] = vld_q[n_stages-2:0];
            assign in_x[n_stages-1:1]   = x_q;
            assign in_r[n_stages-1:1]   = r_q[n_stages-2:0];
        end
    endgenerate

    always_comb begin
        nxt_r = '0;
        for (int s = 0; s < n_stages; s++) begin
            nxt_r[s] = resolve(in_x[s], in_r[s], s);
        end
    end

    // Valid advances every cycle; data only moves with a valid so idle x never reaches y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            r_q   <= '0;
        end else begin
            vld_q <= in_vld;
            for (int s = 0; s < n_stages; s++) begin
                if (in_vld[s]) r_q[s] <= nxt_r[s];
            end
        end
    end

    assign io.y_vld = vld_q[n_stages-1];
    assign io.y     = r_q[n_stages-1];
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb/tb_isqrt_pipe.sv - self-checking bench for isqrt_pipe over n_stages 1,2,4,8,16
module tb_isqrt_pipe;
    localparam int n_dut = 5;   // n_stages = 1 << k, k = 0..4; k = 4 is the default build

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_vld = 1'b0;
    logic [31:0] x = '0;

    logic        y_vld_a [n_dut];
    logic [15:0] y_a     [n_dut];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int unsigned log_cyc [$];
    logic [15:0] log_y   [$];
    int          rd      [n_dut];

    typedef struct {
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < n_dut; k++) begin : g_dut
            isqrt_pipe_if bus ();
            assign bus.x_vld  = x_vld;
            assign bus.x      = x;
            assign y_vld_a[k] = bus.y_vld;
            assign y_a[k]     = bus.y;
            isqrt_pipe #(.n_stages(1 << k)) dut (
                .clk (clk),
                .rst (rst),
                .io  (bus.slave)
            );
        end
    endgenerate

    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        longint r;
        longint lv;
        lv = longint'({32'd0, v});
        r  = longint'($floor($sqrt(real'(lv))));
        while (r * r > lv) r--;
        while ((r + 1) * (r + 1) <= lv) r++;
        return r[15:0];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue log: every accepted argument with its issue cycle and model result.
    always @(posedge clk) begin
        if (!rst && x_vld) begin
            log_cyc.push_back(cyc);
            log_y.push_back(ref_sqrt(x));
        end
        cyc++;
    end

    // Scoreboard: each pipeline must return the log in order, exactly n_stages cycles after issue.
    always @(negedge clk) begin
        for (int k = 0; k < n_dut; k++) begin
            if (rst) begin
                rd[k] = log_cyc.size();
                chk($sformatf("rst_y_vld_n%0d", 1 << k), y_vld_a[k], 0);
            end else if (y_vld_a[k]) begin
                if (rd[k] < log_cyc.size()) begin
                    chk($sformatf("latency_n%0d", 1 << k), cyc - int'(log_cyc[rd[k]]), 1 << k);
                    chk($sformatf("y_n%0d", 1 << k), y_a[k], log_y[rd[k]]);
                    rd[k]++;
                end else begin
                    chk($sformatf("spurious_y_vld_n%0d", 1 << k), y_vld_a[k], 0);
                end
            end else if (rd[k] < log_cyc.size() && cyc - int'(log_cyc[rd[k]]) >= (1 << k)) begin
                chk($sformatf("missing_y_vld_n%0d", 1 << k), y_vld_a[k], 1);
                rd[k]++;
            end
        end
    end

    // Called at posedge+1; checks the default-depth pipeline directly against a fixed expectation.
    task automatic run_single(input logic [31:0] v, input logic [15:0] exp);
        x_vld = 1'b1;
        x     = v;
        @(posedge clk); #1;
        x_vld = 1'b0;
        x     = $urandom;
        repeat (14) @(posedge clk);
        #1 chk("early_y_vld", y_vld_a[4], 0);
        @(posedge clk); #1;
        chk("single_y_vld", y_vld_a[4], 1);
        chk($sformatf("single_y_x%0h", v), y_a[4], exp);
        @(posedge clk); #1;
        chk("pulse_width", y_vld_a[4], 0);
        chk("y_hold", y_a[4], exp);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'd0,        16'd0};
        vecs[1]  = '{32'd1,        16'd1};
        vecs[2]  = '{32'd2,        16'd1};
        vecs[3]  = '{32'd3,        16'd1};
        vecs[4]  = '{32'd4,        16'd2};
        vecs[5]  = '{32'hFFFFFFFF, 16'hFFFF};
        vecs[6]  = '{32'hFFFE0001, 16'hFFFF};
        vecs[7]  = '{32'd143,      16'd11};
        vecs[8]  = '{32'd144,      16'd12};
        vecs[9]  = '{32'd145,      16'd12};
        vecs[10] = '{32'd1000000,  16'd1000};
        vecs[11] = '{32'd999999,   16'd999};

        for (int k = 0; k < n_dut; k++) rd[k] = 0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < n_dut; k++) begin
            chk($sformatf("reset_y_vld_n%0d", 1 << k), y_vld_a[k], 0);
            chk($sformatf("reset_y_n%0d", 1 << k), y_a[k], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_single(vecs[i].x, vecs[i].y);

        // Back-to-back issue of three arguments.
        x_vld = 1'b1;
        x = 32'd9;  @(posedge clk); #1;
        x = 32'd16; @(posedge clk); #1;
        x = 32'd25; @(posedge clk); #1;
        x_vld = 1'b0;
        x = 32'hFFFFFFFF;
        repeat (13) @(posedge clk);
        #1 chk("b2b_vld0", y_vld_a[4], 1); chk("b2b_y0", y_a[4], 3);
        @(posedge clk); #1 chk("b2b_vld1", y_vld_a[4], 1); chk("b2b_y1", y_a[4], 4);
        @(posedge clk); #1 chk("b2b_vld2", y_vld_a[4], 1); chk("b2b_y2", y_a[4], 5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b2b_idle_vld", y_vld_a[4], 0);
            chk("b2b_idle_y", y_a[4], 5);
        end

        // Gapped stream with an all-ones radicand on idle cycles.
        for (int i = 0; i < 6; i++) begin
            x_vld = (i != 1 && i != 4);
            x     = x_vld ? $urandom : 32'hFFFFFFFF;
            @(posedge clk); #1;
        end
        x_vld = 1'b0;
        x     = 32'hFFFFFFFF;
        repeat (20) @(posedge clk);
        #1;

        // Reset in the middle of five in-flight arguments.
        for (int i = 0; i < 5; i++) begin
            x_vld = 1'b1;
            x     = $urandom;
            @(posedge clk); #1;
        end
        x_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < n_dut; k++) begin
            chk($sformatf("midrst_y_vld_n%0d", 1 << k), y_vld_a[k], 0);
            chk($sformatf("midrst_y_n%0d", 1 << k), y_a[k], 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        run_single(32'd49, 16'd7);

        // Random valid pattern, random don't-care x on idle cycles.
        for (int i = 0; i < 500; i++) begin
            x_vld = ($urandom_range(0, 2) != 0);
            x     = $urandom;
            @(posedge clk); #1;
        end

        // Continuous valid for every pipeline depth, with some perfect squares mixed in.
        x_vld = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [31:0] r;
                r = $urandom_range(0, 65535);
                x = r * r;
            end else begin
                x = $urandom;
            end
            @(posedge clk); #1;
        end
        x_vld = 1'b0;
        repeat (24) @(posedge clk);
        #1;

        for (int k = 0; k < n_dut; k++) begin
            chk($sformatf("drained_n%0d", 1 << k), rd[k], log_cyc.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
